// File: rtl/video_pkg.sv
// Shared video constants: 640x480 timing, frame size and scheduler state encoding.
package video_pkg;

  // Scheduler FSM encoding (kept as plain constants for legacy tooling).
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] ISSUE    = 2'b01;
  localparam logic [1:0] WAIT_STS = 2'b10;

  // 640x480 @ 60 Hz timing.
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  // One frame of 24-bit pixels.
  localparam int FRAME_BYTES = H_VISIBLE * V_VISIBLE * 3;

endpackage

// File: rtl/fb_swap_reg.sv
// Front/back framebuffer register: holds the pending address from the CPU and
// promotes it to the current front buffer only when the scheduler starts a frame.
module fb_swap_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] swap_addr,
  input  logic              take,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              swap_ack
);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;

  // Latch requests (latest wins) and promote on frame start; a request that
  // coincides with the frame start is used directly for that frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      cur_addr   <= RST_ADDR;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (take) begin
        if (swap_req) begin
          cur_addr <= swap_addr;
          swap_ack <= 1'b1;
        end else if (pend_valid) begin
          cur_addr <= pend_addr;
          swap_ack <= 1'b1;
        end
        pend_valid <= 1'b0;
      end else if (swap_req) begin
        pend_valid <= 1'b1;
        pend_addr  <= swap_addr;
      end
    end
  end

endmodule

// File: rtl/frame_dma_sched.sv
// Per-frame MM2S DMA scheduler with tear-free framebuffer swapping and sticky
// error flags. Optional statistics counters: define FRAME_DMA_SCHED_STATS_EN.
module frame_dma_sched #(
  parameter int                ADDR_W      = 32,
  parameter int                BTT_W       = 23,
  parameter int                FRAME_BYTES = video_pkg::FRAME_BYTES,
  parameter logic [ADDR_W-1:0] RST_ADDR    = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_addr,
  input  logic              fb_swap_req,
  output logic              fb_swap_ack,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [BTT_W-1:0]  cmd_btt,
  input  logic              sts_valid,
  input  logic              sts_okay,
  output logic              sts_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              err_dma,
  output logic              err_miss,
  input  logic              err_clr
`ifdef FRAME_DMA_SCHED_STATS_EN
  ,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  import video_pkg::*;

  logic [1:0] state;
  logic       go;
  logic       miss;
  logic       sts_done;
  logic       cmd_done;

  assign go       = (state == IDLE) && frame_start && enable;
  assign miss     = (state != IDLE) && frame_start;
  assign cmd_done = (state == ISSUE) && cmd_ready;
  assign sts_done = (state == WAIT_STS) && sts_valid;

  // The command always covers a whole frame and points at the front buffer,
  // which only changes while idle, so both are stable during the handshake.
  assign cmd_btt  = BTT_W'(FRAME_BYTES);
  assign cmd_addr = cur_addr;

  fb_swap_reg #(
    .ADDR_W   (ADDR_W),
    .RST_ADDR (RST_ADDR)
  ) u_swap (
    .clk       (clk),
    .rstn      (rstn),
    .swap_req  (fb_swap_req),
    .swap_addr (fb_addr),
    .take      (go),
    .cur_addr  (cur_addr),
    .swap_ack  (fb_swap_ack)
  );

  // Scheduler FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      sts_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= ISSUE;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (cmd_done) begin
            state     <= WAIT_STS;
            cmd_valid <= 1'b0;
            sts_ready <= 1'b1;
          end
        end
        WAIT_STS: begin
          if (sts_done) begin
            state     <= IDLE;
            sts_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
          sts_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a set event on the same edge beats the clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_dma  <= 1'b0;
      err_miss <= 1'b0;
    end else begin
      if (sts_done && !sts_okay) err_dma <= 1'b1;
      else if (err_clr)          err_dma <= 1'b0;
      if (miss)                  err_miss <= 1'b1;
      else if (err_clr)          err_miss <= 1'b0;
    end
  end

`ifdef FRAME_DMA_SCHED_STATS_EN
  // Good-frame and missed-frame counters; an event coinciding with a clear
  // restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      if (sts_done && sts_okay) frame_cnt <= err_clr ? 32'd1 : frame_cnt + 32'd1;
      else if (err_clr)         frame_cnt <= '0;
      if (miss) begin
        if (err_clr)                    miss_cnt <= 16'd1;
        else if (miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
      end else if (err_clr) begin
        miss_cnt <= '0;
      end
    end
  end
`endif

endmodule
